snitch_icache_flush_ctrl: RTL and testbench

Sequences a full invalidation of the L1 instruction-cache tag array on request.
- On a flush request it stalls new lookups and waits until all in-flight refills and the lookup pipeline have drained.
- It then sweeps every line/set through the tag invalidate port and acknowledges completion.
- It sits beside the refill/miss handler and drives the lookup stage's stall and the tag array's invalidate write port.

---
 rtl/snitch_icache_flush_ctrl.sv | 114 +++++++++++
 tb/tb_snitch_icache_flush_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snitch_icache_flush_ctrl.sv
// Flush sequencer for the L1 instruction cache: drains lookups and refills,
// then walks the tag array invalidating every line before acknowledging.
module snitch_icache_flush_ctrl #(
  parameter int unsigned LINE_COUNT    = 128,
  parameter int unsigned SET_COUNT     = 4,
  parameter bit          PARALLEL_SETS = 1'b1,
  parameter int unsigned COUNT_ALIGN   = $clog2(LINE_COUNT),
  parameter int unsigned SET_ALIGN     = $clog2(SET_COUNT)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_valid_i,
  output logic                   flush_ready_o,
  output logic                   flush_busy_o,
  input  logic                   refill_pending_i,
  input  logic                   lookup_idle_i,
  output logic                   lookup_stall_o,
  output logic [COUNT_ALIGN-1:0] inv_addr_o,
  output logic [SET_COUNT-1:0]   inv_set_mask_o,
  output logic                   inv_valid_o,
  input  logic                   inv_ready_i
);

  localparam int unsigned CW =
    PARALLEL_SETS ? COUNT_ALIGN : COUNT_ALIGN + SET_ALIGN;
  localparam int unsigned BEATS =
    PARALLEL_SETS ? LINE_COUNT : LINE_COUNT * SET_COUNT;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [1:0] {
    Idle,
    Drain,
    Sweep,
    Done
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      Idle: begin
        if (flush_valid_i) state_d = Drain;
      end
      Drain: begin
        if (!refill_pending_i && lookup_idle_i) begin
          state_d = Sweep;
          cnt_d   = '0;
        end
      end
      Sweep: begin
        if (inv_ready_i) begin
          if (cnt_q == LAST) state_d = Done;
          else               cnt_d   = cnt_q + 1'b1;
        end
      end
      Done: begin
        state_d = Idle;
        cnt_d   = '0;
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign flush_busy_o   = (state_q != Idle);
  assign lookup_stall_o = (state_q != Idle);
  assign inv_valid_o    = (state_q == Sweep);
  assign flush_ready_o  = (state_q == Done);

  // Address and mask are gated so every output reads 0 outside the sweep.
  if (PARALLEL_SETS) begin : g_par
    assign inv_addr_o     = inv_valid_o ? cnt_q : '0;
    assign inv_set_mask_o = {SET_COUNT{inv_valid_o}};
  end else begin : g_ser
    logic [SET_COUNT-1:0] one;
    assign one = {{(SET_COUNT-1){1'b0}}, 1'b1};
    assign inv_addr_o =
      inv_valid_o ? cnt_q[CW-1:SET_ALIGN] : '0;
    assign inv_set_mask_o =
      inv_valid_o ? (one << cnt_q[SET_ALIGN-1:0]) : '0;
  end

`ifndef SYNTHESIS
  if (LINE_COUNT < 2 ||
      (LINE_COUNT & (LINE_COUNT - 1)) != 0) begin : g_chk_lines
    $error("LINE_COUNT must be a power of two >= 2");
  end
  if (SET_COUNT < 2 ||
      (SET_COUNT & (SET_COUNT - 1)) != 0) begin : g_chk_sets
    $error("SET_COUNT must be a power of two >= 2");
  end

  a_inv_stall: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    inv_valid_o |-> lookup_stall_o);

  a_ack_pulse: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    flush_ready_o |=> !flush_ready_o);
`endif

endmodule

// File: tb/tb_snitch_icache_flush_ctrl.sv
// Bench for the flush sequencer: two instances (parallel and per-way
// sweeps), directed timing checks plus a scoreboard of expected beats.
module tb_snitch_icache_flush_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fv = 1'b0;
  logic rp = 1'b0;
  logic li = 1'b1;
  logic ir = 1'b1;
  logic sel = 1'b0;

  always #5 clk = ~clk;

  logic       fr0, bz0, st0, iv0;
  logic [6:0] ad0;
  logic [3:0] mk0;
  logic       fr1, bz1, st1, iv1;
  logic [1:0] ad1;
  logic [3:0] mk1;

  snitch_icache_flush_ctrl #(
    .LINE_COUNT(128), .SET_COUNT(4), .PARALLEL_SETS(1'b1)
  ) u_par (
    .clk_i(clk), .rst_ni(rst_n),
    .flush_valid_i(fv & ~sel), .flush_ready_o(fr0),
    .flush_busy_o(bz0), .refill_pending_i(rp),
    .lookup_idle_i(li), .lookup_stall_o(st0),
    .inv_addr_o(ad0), .inv_set_mask_o(mk0),
    .inv_valid_o(iv0), .inv_ready_i(ir)
  );

  snitch_icache_flush_ctrl #(
    .LINE_COUNT(4), .SET_COUNT(4), .PARALLEL_SETS(1'b0)
  ) u_ser (
    .clk_i(clk), .rst_ni(rst_n),
    .flush_valid_i(fv & sel), .flush_ready_o(fr1),
    .flush_busy_o(bz1), .refill_pending_i(rp),
    .lookup_idle_i(li), .lookup_stall_o(st1),
    .inv_addr_o(ad1), .inv_set_mask_o(mk1),
    .inv_valid_o(iv1), .inv_ready_i(ir)
  );

  logic       c_fr, c_bz, c_st, c_iv;
  logic [6:0] c_ad;
  logic [3:0] c_mk;
  assign c_fr = sel ? fr1 : fr0;
  assign c_bz = sel ? bz1 : bz0;
  assign c_st = sel ? st1 : st0;
  assign c_iv = sel ? iv1 : iv0;
  assign c_ad = sel ? {5'b0, ad1} : ad0;
  assign c_mk = sel ? mk1 : mk0;

  typedef struct packed {
    logic       ack;
    logic [6:0] addr;
    logic [3:0] mask;
  } exp_t;

  exp_t exp_q[$];
  int pass_cnt = 0;
  int tot_cnt = 0;

  function automatic void chk(string nm, int act, int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endfunction

  function automatic void fail(string nm);
    tot_cnt++;
    $display("FAIL %s: got output with empty expectation queue", nm);
  endfunction

  // Reference: a flush writes every line once; per-way mode has the way
  // as the inner loop. An ack marker follows the last write.
  function automatic void push_flush();
    exp_t e;
    e.ack = 1'b0;
    if (sel == 1'b0) begin
      for (int a = 0; a < 128; a++) begin
        e.addr = 7'(a);
        e.mask = 4'hF;
        exp_q.push_back(e);
      end
    end else begin
      for (int a = 0; a < 4; a++)
        for (int w = 0; w < 4; w++) begin
          e.addr = 7'(a);
          e.mask = 4'(1 << w);
          exp_q.push_back(e);
        end
    end
    e.ack  = 1'b1;
    e.addr = '0;
    e.mask = '0;
    exp_q.push_back(e);
  endfunction

  logic       pv, pr;
  logic [6:0] pa;
  logic [3:0] pm;

  always @(negedge clk) begin : mon
    automatic exp_t e;
    if (!rst_n) begin
      pv <= 1'b0;
    end else begin
      if (c_iv) chk("stall_with_valid", c_st, 1);
      if (pv && !pr && c_iv) begin
        chk("addr_stable", c_ad, pa);
        chk("mask_stable", c_mk, pm);
      end
      if (c_iv && ir) begin
        if (exp_q.size() == 0) fail("beat_unexpected");
        else begin
          e = exp_q.pop_front();
          chk("beat_kind", e.ack, 0);
          chk("beat_addr", c_ad, e.addr);
          chk("beat_mask", c_mk, e.mask);
        end
      end
      if (c_fr) begin
        if (exp_q.size() == 0) fail("ack_unexpected");
        else begin
          e = exp_q.pop_front();
          chk("ack_kind", e.ack, 1);
        end
      end
      pv <= c_iv;
      pr <= ir;
      pa <= c_ad;
      pm <= c_mk;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Cycle-exact flush with a drain delay of d cycles and no backpressure.
  task automatic run_timed(input int d);
    int nb;
    int ex;
    bit s, v, a;
    nb = sel ? 16 : 128;
    push_flush();
    li = 1'b1;
    ir = 1'b1;
    rp = (d > 0);
    fv = 1'b1;
    chk("timed_cycle0", {c_st, c_iv, c_fr, c_bz}, 0);
    for (int c = 1; c <= nb + d + 3; c++) begin
      cyc();
      s  = (c <= nb + d + 2);
      v  = (c >= d + 2) && (c <= d + 1 + nb);
      a  = (c == d + 2 + nb);
      ex = {28'd0, s, v, a, s};
      chk("timed_outputs", {c_st, c_iv, c_fr, c_bz}, ex);
      fv = 1'b0;
      rp = (c <= d);
    end
  endtask

  task automatic run_random();
    bit started;
    bit done;
    started = 1'b0;
    done = 1'b0;
    push_flush();
    fv = 1'b1;
    for (int n = 0; n < 6000; n++) begin
      ir = 1'($urandom % 2);
      rp = ($urandom % 3 == 0);
      li = ($urandom % 4 != 0);
      cyc();
      if (c_bz) begin
        started = 1'b1;
        fv = 1'b0;
      end
      if (started && !c_bz) begin
        done = 1'b1;
        break;
      end
    end
    chk("random_done", done, 1);
    chk("random_queue_empty", exp_q.size(), 0);
    ir = 1'b1;
    rp = 1'b0;
    li = 1'b1;
    fv = 1'b0;
    cyc();
  endtask

  task automatic run_reset_mid();
    bit hit;
    hit = 1'b0;
    push_flush();
    fv = 1'b1;
    for (int n = 0; n < 400; n++) begin
      cyc();
      fv = 1'b0;
      if (c_iv && c_ad == 7'd37) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reached_beat37", hit, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_async_outputs",
        {c_st, c_iv, c_fr, c_bz, c_ad, c_mk}, 0);
    exp_q.delete();
    repeat (2) begin
      cyc();
      chk("reset_held_outputs",
          {c_st, c_iv, c_fr, c_bz, c_ad, c_mk}, 0);
    end
    rst_n = 1'b1;
    cyc();
    run_timed(0);
  endtask

  task automatic run_rearm();
    bit done;
    done = 1'b0;
    push_flush();
    push_flush();
    rp = 1'b0;
    li = 1'b1;
    ir = 1'b1;
    fv = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      if (c == 19) chk("rearm_idle", {c_st, c_bz}, 0);
      if (c == 20)
        chk("rearm_drain", {c_st, c_iv, c_fr, c_bz}, 4'b1001);
      fv = (c >= 2 && c <= 16) ? 1'($urandom % 2) : 1'b1;
    end
    fv = 1'b0;
    for (int n = 0; n < 100; n++) begin
      cyc();
      if (!c_bz) begin
        done = 1'b1;
        break;
      end
    end
    chk("rearm_done", done, 1);
    chk("rearm_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) cyc();
    sel = 1'b0;
    #1;
    chk("reset_par", {c_st, c_iv, c_fr, c_bz, c_ad, c_mk}, 0);
    sel = 1'b1;
    #1;
    chk("reset_ser", {c_st, c_iv, c_fr, c_bz, c_ad, c_mk}, 0);
    rst_n = 1'b1;
    cyc();

    sel = 1'b0;
    run_timed(0);
    sel = 1'b1;
    run_timed(0);
    sel = 1'b0;
    run_timed(10);
    sel = 1'b1;
    run_timed(3);

    for (int i = 0; i < 3; i++) begin
      sel = 1'b0;
      run_random();
      sel = 1'b1;
      run_random();
    end

    sel = 1'b0;
    run_reset_mid();

    sel = 1'b1;
    run_rearm();

    repeat (2) cyc();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
